// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate decoder with a 2-entry skid buffer and illegal-opcode counter
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;
  entry_t dec, main_e, skid_e;
  logic main_v, skid_v, accept, drain, sh;
  logic [6:0] op;
  logic [5:0] shamt;
  assign op     = in_instr[6:0];
  assign sh     = op == 7'b0010011 && in_instr[13:12] == 2'b01;
  // bit 25 belongs to the shift amount only on 64-bit datapaths
  assign shamt  = {XLEN == 64 && in_instr[25], in_instr[24:20]};
  assign accept = in_valid && in_ready;
  assign drain  = main_v && out_ready;
  assign in_ready    = !skid_v;
  assign out_valid   = main_v;
  assign out_imm     = main_e.imm;
  assign out_fmt     = main_e.fmt;
  assign out_illegal = main_e.ill;
  always_comb begin
    dec = '0;
    case (op)
      7'b0000011, 7'b1100111: begin
        dec.fmt = 3'd1;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0010011: begin
        dec.fmt = sh ? 3'd6 : 3'd1;
        dec.imm = sh ? XLEN'(shamt) : XLEN'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec.fmt = 3'd2;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = 3'd3;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = 3'd4;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = 3'd5;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      end
      7'b0110011: dec.fmt = 3'd0;
      default: begin
        dec.fmt = 3'd7;
        dec.ill = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_e        <= '0;
      skid_e        <= '0;
      main_v        <= 1'b0;
      skid_v        <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (drain && skid_v) begin
        main_e <= skid_e;
        skid_v <= 1'b0;
      end else if (drain) begin
        main_v <= accept;
        if (accept) main_e <= dec;
      end else if (accept && !main_v) begin
        main_e <= dec;
        main_v <= 1'b1;
      end else if (accept) begin
        skid_e <= dec;
        skid_v <= 1'b1;
      end
      if (accept && dec.ill && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN=32 and XLEN=64 against a FIFO-level behavioural model
module tb_imm_gen_pipe;
  logic        clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = '0;
  logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [1:0]  cnt32, cnt64;
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  int mcnt = 0;
  bit started = 0;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .illegal_count(cnt32));
  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .illegal_count(cnt64));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_imm(input logic [31:0] x, input bit w64);
    longint sx, r;
    sx = longint'($signed(x));
    case (x[6:0])
      7'h03, 7'h67: r = sx >>> 20;
      7'h13: r = (x[13:12] == 2'b01) ? longint'(w64 ? x[25:20] : {1'b0, x[24:20]}) : sx >>> 20;
      7'h23: r = ((sx >>> 25) <<< 5) | longint'(x[11:7]);
      7'h63: r = ((sx >>> 31) <<< 12) | (longint'(x[7]) << 11) | (longint'(x[30:25]) << 5) | (longint'(x[11:8]) << 1);
      7'h37, 7'h17: r = sx & ~64'hFFF;
      7'h6F: r = ((sx >>> 31) <<< 20) | (longint'(x[19:12]) << 12) | (longint'(x[20]) << 11) | (longint'(x[30:21]) << 1);
      default: r = 0;
    endcase
    return w64 ? r : {32'b0, r[31:0]};
  endfunction

  function automatic logic [2:0] model_fmt(input logic [31:0] x);
    case (x[6:0])
      7'h03, 7'h67: return 3'd1;
      7'h13: return (x[13:12] == 2'b01) ? 3'd6 : 3'd1;
      7'h23: return 3'd2;
      7'h63: return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F: return 3'd5;
      7'h33: return 3'd0;
      default: return 3'd7;
    endcase
  endfunction

  // compare against the model, then advance the model to the state after the coming edge
  always @(negedge clk) begin
    if (reset) started = 1;
    if (started && !reset) begin
      chk("out_valid32", ov32, q.size() > 0);
      chk("out_valid64", ov64, q.size() > 0);
      chk("in_ready32", rdy32, q.size() < 2);
      chk("in_ready64", rdy64, q.size() < 2);
      chk("count32", cnt32, mcnt);
      chk("count64", cnt64, mcnt);
      if (q.size() > 0) begin
        chk("imm32", imm32, model_imm(q[0], 0));
        chk("imm64", imm64, model_imm(q[0], 1));
        chk("fmt32", fmt32, model_fmt(q[0]));
        chk("fmt64", fmt64, model_fmt(q[0]));
        chk("ill32", ill32, model_fmt(q[0]) == 3'd7);
        chk("ill64", ill64, model_fmt(q[0]) == 3'd7);
      end
    end
    if (reset) begin
      q.delete();
      mcnt = 0;
    end else if (started) begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      else if (in_valid && q.size() < 2) begin
        q.push_back(in_instr);
        if (model_fmt(in_instr) == 3'd7 && mcnt < 3) mcnt++;
      end
      if (q.size() < 2 && in_valid && out_ready && q.size() == 0) begin
        q.push_back(in_instr);
        if (model_fmt(in_instr) == 3'd7 && mcnt < 3) mcnt++;
      end
    end
  end

  task automatic drive(input logic [31:0] x);
    int n = 0;
    in_instr = x;
    in_valid = 1;
    while (!rdy32 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 10) chk("drive_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] e32, input logic [63:0] e64, input logic [2:0] f);
    @(negedge clk);
    chk({name, "_valid"}, ov32, 1);
    chk({name, "_imm32"}, imm32, e32);
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_fmt"}, fmt32, f);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] tbl[10] = '{32'hFFC12083, 32'h00112423, 32'hFE000CE3, 32'h123452B7, 32'h4030D093,
                           32'h0000000B, 32'h0040006F, 32'h00000033, 32'h03F09093, 32'h800002B7};

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_out_valid", ov32, 0);
    chk("rst_in_ready", rdy32, 1);
    chk("rst_out_imm", imm32, 0);
    chk("rst_out_fmt", fmt32, 0);
    chk("rst_out_illegal", ill32, 0);
    chk("rst_count", cnt32, 0);
    @(posedge clk);
    #1;
    drive(32'hFFC12083); expect_out("load",  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1);
    drive(32'h00112423); expect_out("store", 32'h00000008, 64'h0000000000000008, 3'd2);
    drive(32'hFE000CE3); expect_out("branch", 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3);
    drive(32'h123452B7); expect_out("lui",   32'h12345000, 64'h0000000012345000, 3'd4);
    drive(32'h4030D093); expect_out("srai",  32'h00000003, 64'h0000000000000003, 3'd6);
    drive(32'h800002B7); expect_out("lui_neg", 32'h80000000, 64'hFFFFFFFF80000000, 3'd4);
    drive(32'h0040006F); expect_out("jal",   32'h00000004, 64'h0000000000000004, 3'd5);
    drive(32'h00000033); expect_out("rtype", 32'h00000000, 64'h0000000000000000, 3'd0);
    drive(32'h03F09093); expect_out("slli63", 32'h0000001F, 64'h000000000000003F, 3'd6);
    idle(2);
    // backpressure: two accepted, third held, then all three drain back to back
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'hFFC12083;
    @(posedge clk); #1;
    in_instr = 32'h00112423;
    @(posedge clk); #1;
    in_instr = 32'h123452B7;
    @(negedge clk);
    chk("bp_ready_low", rdy32, 0);
    chk("bp_head", imm32, 32'hFFFFFFFC);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_stable_imm", imm32, 32'hFFFFFFFC);
    chk("bp_stable_fmt", fmt32, 1);
    chk("bp_still_full", rdy32, 0);
    @(posedge clk); #1;
    out_ready = 1;
    expect_out("bp_a", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1);
    @(posedge clk); #1;
    expect_out("bp_b", 32'h00000008, 64'h0000000000000008, 3'd2);
    chk("bp_ready_back", rdy32, 1);
    @(posedge clk); #1;
    in_valid = 0;
    expect_out("bp_c", 32'h12345000, 64'h0000000012345000, 3'd4);
    idle(2);
    // mixed handshake pattern, checked by the model every cycle
    begin
      int k = 0;
      for (int i = 0; i < 60; i++) begin
        out_ready = (i % 3) != 0;
        in_valid = (i % 4) != 1 && k < 10;
        in_instr = tbl[k < 10 ? k : 9];
        @(negedge clk);
        if (in_valid && rdy32) k++;
        @(posedge clk);
        #1;
      end
      chk("mixed_all_sent", k, 10);
    end
    out_ready = 1;
    idle(4);
    // illegal opcodes saturate the 2-bit counter
    repeat (5) begin
      drive(32'h0000007F);
      expect_out("illegal", 32'h0, 64'h0, 3'd7);
      chk("illegal_flag", ill32, 1);
    end
    chk("illegal_sat", cnt32, 3);
    chk("illegal_sat64", cnt64, 3);
    idle(2);
    // reset with both entries full
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'hFFC12083;
    @(posedge clk); #1;
    in_instr = 32'h00112423;
    @(posedge clk); #1;
    in_instr = 32'h0000007F;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    in_valid = 0;
    @(negedge clk);
    chk("mid_rst_valid", ov32, 0);
    chk("mid_rst_ready", rdy32, 1);
    chk("mid_rst_count", cnt32, 0);
    chk("mid_rst_count64", cnt64, 0);
    out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_stale", ov32, 0);
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
